mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max WAIT cycles before abort (1..255).
REQ-002 SHALL have port: clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports per requester i in {0 = CPU memory controller, 1 = DMA}: req_i in 1; we_i in 1; addr_i in 15; wdata_i in 32.
REQ-005 SHALL have ports per requester i: ack_i out 1 (one-cycle completion pulse); err_i out 1 (timeout flag, valid with ack_i); rdata out 32 (shared read data, valid with any ack).
REQ-006 SHALL have memory-side ports: mem_addr out 15; mem_wdata out 32; mem_we out 1; mem_readstart out 1; mem_rdata in 32; mem_readrdy in 1; mem_saverdy in 1.
REQ-007 SHALL have port: busy out 1, high in every state except IDLE.

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-009 IDLE: if any req_i high, SHALL latch winner, its we/addr/wdata, and go ISSUE; else stay.
REQ-010 Arbitration SHALL be round-robin: on simultaneous req_0 and req_1, grant the one not granted last; after reset, requester 0 wins the first tie.
REQ-011 ISSUE (one cycle): SHALL drive mem_addr/mem_wdata from latched values; read -> mem_readstart=1 for this cycle only; write -> mem_we=1; go WAIT.
REQ-012 WAIT: SHALL hold mem_addr/mem_wdata; write keeps mem_we=1 until mem_saverdy; mem_readstart=0.
REQ-013 WAIT: read completes on mem_readrdy, capturing mem_rdata into rdata; write completes on mem_saverdy; either -> DONE.
REQ-014 mem_readrdy/mem_saverdy SHALL be ignored in IDLE, ISSUE and DONE; the rdy signal not matching the access type is ignored in WAIT.
REQ-015 WAIT SHALL count cycles in an 8-bit counter cleared on ISSUE; at count == TIMEOUT without completion -> DONE with error flag set, mem_we dropped, rdata unchanged.
REQ-016 DONE (one cycle): SHALL pulse ack of the latched winner only, err_i = error flag; go IDLE.
REQ-017 Minimum latency: req sampled in IDLE cycle N, rdy in cycle N+2, ack in cycle N+3.
REQ-018 Requester SHALL hold req/we/addr/wdata until its ack; req still high in the cycle after ack is a new request.
REQ-019 Changes of requester inputs after latching SHALL NOT affect an access in flight.
REQ-020 Request from the non-granted requester during an access SHALL wait and be granted in the next IDLE evaluation.
REQ-021 rdata SHALL hold its last captured value until the next successful read.

Reset
REQ-022 On rst all outputs SHALL be 0, FSM = IDLE, counter = 0, last-grant = 1 (so requester 0 wins first tie), latched request cleared.
REQ-023 Reset mid-access SHALL abort it immediately with no ack; mem_we and mem_readstart drop asynchronously.

Structure
REQ-024 State encodings (IDLE, ISSUE, WAIT, DONE) and requester index constants SHALL live in the shared processor package.
REQ-025 Round-robin grant logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output grant index, valid).

Verification
REQ-026 Single read: req_0=1, we_0=0, addr_0=0x0005; mem_readrdy in WAIT with mem_rdata=0xDEADBEEF -> one mem_readstart pulse, mem_addr=0x0005, ack_0 at N+3, rdata=0xDEADBEEF, err_0=0.
REQ-027 Write: req_1=1, we_1=1, addr_1=0x000B, wdata_1=0x12345678; mem_saverdy 4 cycles after ISSUE -> mem_we high ISSUE through saverdy cycle, ack_1 once, no readstart.
REQ-028 Tie: req_0 and req_1 held high continuously after reset -> grants alternate 0,1,0,1; each ack only to its owner.
REQ-029 Timeout: TIMEOUT=8, read, no readrdy -> ack_0 with err_0=1 after 8 WAIT cycles; rdata unchanged; next request serviced normally.
REQ-030 Reset in WAIT of a write -> mem_we=0 immediately, no ack; following req_0 read completes normally and wins tie.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester indices and datapath widths.
package mem_arbiter_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins,
// otherwise the single active requester wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req[REQ_CPU] && req[REQ_DMA]) begin
            grant = ~last;
        end else if (req[REQ_DMA]) begin
            grant = REQ_DMA;
        end else begin
            grant = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the CPU memory controller and the DMA engine onto one
// single-access memory port, with round-robin ties and a WAIT timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              ack_0,
    output logic              err_0,
    output logic              ack_1,
    output logic              err_1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_readstart,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_readrdy,
    input  logic              mem_saverdy,
    output logic              busy,
    output state_e            dbg_state
);

    // Requester handshake: req_i with we/addr/wdata is held until ack_i, which
    // pulses for one cycle together with err_i; req_i still high the cycle
    // after ack_i is a fresh request. Request fields are latched at grant.

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e           state;
    logic             last;
    logic             sel_id;
    logic             sel_we;
    logic [CNT_W-1:0] cnt;

    logic              grant;
    logic              grant_valid;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              done_ok;
    logic              done_to;

    rr_arb2 u_rr (
        .req   ({req_1, req_0}),
        .last  (last),
        .grant (grant),
        .valid (grant_valid)
    );

    assign g_we    = (grant == REQ_DMA) ? we_1    : we_0;
    assign g_addr  = (grant == REQ_DMA) ? addr_1  : addr_0;
    assign g_wdata = (grant == REQ_DMA) ? wdata_1 : wdata_0;

    // Only the ready matching the latched access type can complete it.
    assign done_ok = sel_we ? mem_saverdy : mem_readrdy;
    assign done_to = ((cnt + 1'b1) == TO_CNT);

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            last          <= REQ_DMA;
            sel_id        <= REQ_CPU;
            sel_we        <= 1'b0;
            cnt           <= '0;
            ack_0         <= 1'b0;
            err_0         <= 1'b0;
            ack_1         <= 1'b0;
            err_1         <= 1'b0;
            rdata         <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_readstart <= 1'b0;
            busy          <= 1'b0;
        end else begin
            ack_0         <= 1'b0;
            err_0         <= 1'b0;
            ack_1         <= 1'b0;
            err_1         <= 1'b0;
            mem_readstart <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state         <= ST_ISSUE;
                        busy          <= 1'b1;
                        last          <= grant;
                        sel_id        <= grant;
                        sel_we        <= g_we;
                        mem_addr      <= g_addr;
                        mem_wdata     <= g_wdata;
                        mem_we        <= g_we;
                        mem_readstart <= ~g_we;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the last allowed cycle beats the timeout.
                    if (done_ok || done_to) begin
                        state  <= ST_DONE;
                        mem_we <= 1'b0;
                        ack_0  <= (sel_id == REQ_CPU);
                        ack_1  <= (sel_id == REQ_DMA);
                        err_0  <= ~done_ok && (sel_id == REQ_CPU);
                        err_1  <= ~done_ok && (sel_id == REQ_DMA);
                        if (done_ok && !sel_we) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level
// model of grant order, access timing, read data and timeout.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        req_0, we_0, req_1, we_1;
    logic [14:0] addr_0, addr_1;
    logic [31:0] wdata_0, wdata_1;
    logic        ack_0, err_0, ack_1, err_1;
    logic [31:0] rdata;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_readstart;
    logic [31:0] mem_rdata;
    logic        mem_readrdy, mem_saverdy;
    logic        busy;
    state_e      dbg_state;

    int          checks = 0;
    int          errors = 0;
    bit          m_last = 1'b1;
    logic [31:0] m_rdata = '0;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .ack_0(ack_0), .err_0(err_0), .ack_1(ack_1), .err_1(err_1),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_readstart(mem_readstart), .mem_rdata(mem_rdata),
        .mem_readrdy(mem_readrdy), .mem_saverdy(mem_saverdy),
        .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Spec rule: a lone requester wins; on a tie, the one not granted last.
    function automatic bit pick(input bit r0, input bit r1, input bit last_g);
        if (r0 && r1) return !last_g;
        return r1;
    endfunction

    task automatic set_req(input int i, input bit r, input bit we, input logic [14:0] a, input logic [31:0] d);
        if (i == 0) begin req_0 = r; we_0 = we; addr_0 = a; wdata_0 = d; end
        else        begin req_1 = r; we_1 = we; addr_1 = a; wdata_1 = d; end
    endtask

    // Called at the negedge of an IDLE cycle with requests already driven.
    // delay = WAIT-cycle index of the ready pulse; delay >= TO means none.
    task automatic run_access(input int delay, input bit scramble, input bit fix_rd,
                              input logic [31:0] rd_val, output bit win);
        bit          to;
        int          n_wait;
        logic        we_w;
        logic [14:0] a_w;
        logic [31:0] d_w;
        logic [31:0] exp_rd;
        logic [1:0]  own;
        win    = pick(req_0, req_1, m_last);
        m_last = win;
        we_w   = win ? we_1 : we_0;
        a_w    = win ? addr_1 : addr_0;
        d_w    = win ? wdata_1 : wdata_0;
        own    = win ? 2'b10 : 2'b01;
        to     = (delay >= TO);
        n_wait = to ? TO : delay + 1;
        exp_rd = m_rdata;

        @(negedge clk);
        chk("issue_busy", busy, 1);
        chk("issue_addr", mem_addr, a_w);
        chk("issue_wdata", mem_wdata, d_w);
        chk("issue_we", mem_we, we_w);
        chk("issue_readstart", mem_readstart, !we_w);
        chk("issue_ack", {ack_1, ack_0}, 0);
        if (scramble)
            set_req(win, 1'b1, 1'($urandom), 15'($urandom), $urandom);
        mem_readrdy = 1'b1;
        mem_saverdy = 1'b1;

        for (int k = 0; k < n_wait; k++) begin
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_addr", mem_addr, a_w);
            chk("wait_wdata", mem_wdata, d_w);
            chk("wait_we", mem_we, we_w);
            chk("wait_readstart", mem_readstart, 0);
            chk("wait_ack", {ack_1, ack_0}, 0);
            chk("wait_rdata", rdata, m_rdata);
            mem_rdata = $urandom;
            if (!to && k == delay && fix_rd) mem_rdata = rd_val;
            if (we_w) begin
                mem_saverdy = (!to && k == delay);
                mem_readrdy = 1'($urandom);
            end else begin
                mem_readrdy = (!to && k == delay);
                mem_saverdy = 1'($urandom);
            end
            if (!to && k == delay && !we_w) exp_rd = mem_rdata;
        end

        @(negedge clk);
        m_rdata = exp_rd;
        chk("done_ack", {ack_1, ack_0}, own);
        chk("done_err", {err_1, err_0}, to ? own : 2'b00);
        chk("done_rdata", rdata, m_rdata);
        chk("done_we", mem_we, 0);
        chk("done_readstart", mem_readstart, 0);
        chk("done_busy", busy, 1);
        mem_readrdy = 1'($urandom);
        mem_saverdy = 1'($urandom);

        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_ack", {ack_1, ack_0}, 0);
        chk("idle_rdata", rdata, m_rdata);
    endtask

    initial begin
        bit win;
        bit r0, r1;
        rst = 1'b1;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        mem_rdata = '0; mem_readrdy = 0; mem_saverdy = 0;
        #1;
        chk("rst_outputs", {ack_0, err_0, ack_1, err_1, mem_we, mem_readstart, busy}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single read at 0x0005.
        set_req(0, 1, 0, 15'h0005, $urandom);
        run_access(0, 0, 1, 32'hDEADBEEF, win);
        req_0 = 0;
        chk("read_winner", win, 0);
        chk("read_rdata", rdata, 32'hDEADBEEF);

        // Write from DMA, saverdy four cycles after ISSUE.
        set_req(1, 1, 1, 15'h000B, 32'h12345678);
        run_access(3, 0, 0, '0, win);
        req_1 = 0;
        chk("write_winner", win, 1);
        chk("write_rdata_kept", rdata, 32'hDEADBEEF);

        // Continuous tie alternates grants.
        set_req(0, 1, 1'($urandom), 15'($urandom), $urandom);
        set_req(1, 1, 1'($urandom), 15'($urandom), $urandom);
        for (int i = 0; i < 4; i++) begin
            run_access(int'($urandom_range(0, 2)), 0, 0, '0, win);
            chk("tie_order", win, i % 2);
        end
        req_0 = 0; req_1 = 0;
        @(negedge clk);

        // Timeout on a read, then a normal read.
        set_req(0, 1, 0, 15'h0123, $urandom);
        run_access(TO, 0, 0, '0, win);
        chk("timeout_rdata_kept", rdata, m_rdata);
        run_access(1, 0, 1, 32'hCAFEF00D, win);
        req_0 = 0;
        chk("after_timeout_rdata", rdata, 32'hCAFEF00D);

        // Reset during WAIT of a write.
        set_req(1, 1, 1, 15'h0042, 32'hA5A5A5A5);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_we", mem_we, 1);
        mem_saverdy = 0; mem_readrdy = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_outputs", {ack_0, ack_1, busy, mem_readstart}, 0);
        m_last  = 1'b1;
        m_rdata = '0;
        @(negedge clk);
        chk("mid_rst_noack", {ack_1, ack_0}, 0);
        rst = 1'b0;
        set_req(0, 1, 0, 15'h0777, $urandom);
        set_req(1, 1, 1, 15'h0042, 32'hA5A5A5A5);
        run_access(2, 0, 1, 32'h0BADF00D, win);
        chk("post_rst_win", win, 0);
        chk("post_rst_rdata", rdata, 32'h0BADF00D);
        req_0 = 0;
        run_access(0, 0, 0, '0, win);
        req_1 = 0;
        @(negedge clk);

        // Randomized traffic; a pending loser keeps its request untouched.
        win = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!req_0 || win == 0) begin
                r0 = 1'($urandom);
                set_req(0, r0, 1'($urandom), 15'($urandom), $urandom);
            end
            if (!req_1 || win == 1) begin
                r1 = 1'($urandom);
                set_req(1, r1, 1'($urandom), 15'($urandom), $urandom);
            end
            if (!req_0 && !req_1) begin
                @(negedge clk);
                chk("rand_idle_busy", busy, 0);
            end else begin
                run_access(int'($urandom_range(0, TO + 2)), 1'($urandom), 0, '0, win);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
